// File: rtl/core_pkg.sv
// Shared types and constants for the execute-stage integer divider.
package core_pkg;

    localparam int          DIV_CYCLES   = 32;
    localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_OVF_QUO  = 32'h8000_0000;

    typedef enum logic [1:0] {
        DIV_S = 2'b00,
        DIV_U = 2'b01,
        REM_S = 2'b10,
        REM_U = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_e;

    function automatic logic op_signed(input div_op_e op);
        return (op == DIV_S) || (op == REM_S);
    endfunction

    function automatic logic op_rem(input div_op_e op);
        return (op == REM_S) || (op == REM_U);
    endfunction

endpackage

// File: rtl/core_div_fixup.sv
// Sign fixup and RISC-V corner-case result selection for the divider.
// Latency: combinational. Backpressure: none (pure function of its inputs).
// Divide-by-zero and signed overflow override the sign-corrected values.
module core_div_fixup
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] quo,
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] dividend,
    input  logic            quo_neg,
    input  logic            rem_neg,
    input  logic            div_zero,
    input  logic            sgn_ovf,
    input  div_op_e         op,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;

    always_comb begin
        q_fix = quo_neg ? -quo : quo;
        r_fix = rem_neg ? -rem : rem;
        if (div_zero) begin
            q_fix = DIV_ZERO_QUO;
            r_fix = dividend;
        end else if (sgn_ovf) begin
            q_fix = DIV_OVF_QUO;
            r_fix = '0;
        end
        result = op_rem(op) ? r_fix : q_fix;
    end

endmodule

// File: rtl/core_div.sv
// Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), option CORE_DIV_FAST_SPECIAL_EN.
// Latency: resp_valid 34 cycles after acceptance; 1 cycle for div-by-zero/overflow when the option is on.
// Backpressure: req_ready only in IDLE; result held in DONE until resp_ready; flush aborts to IDLE.
module core_div
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  div_op_e         div_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result
);

`ifdef CORE_DIV_FAST_SPECIAL_EN
    localparam bit FAST_SPECIAL = 1'b1;
`else
    localparam bit FAST_SPECIAL = 1'b0;
`endif

    div_state_e      state_q, state_d;
    div_op_e         op_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q, a_q, result_q;
    logic            quo_neg_q, rem_neg_q, zero_q, ovf_q;
    logic [4:0]      cnt_q;

    logic            in_sgn, in_zero, in_ovf, special, accept;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            rem_ge;

    assign in_sgn  = op_signed(div_op);
    assign a_mag   = (in_sgn && src_a[XLEN-1]) ? -src_a : src_a;
    assign b_mag   = (in_sgn && src_b[XLEN-1]) ? -src_b : src_b;
    assign in_zero = (src_b == '0);
    assign in_ovf  = in_sgn && (src_a == DIV_OVF_QUO) && (src_b == '1);
    assign special = in_zero || in_ovf;
    assign accept  = (state_q == IDLE) && req_valid && !flush;

    // One restoring step: shift the next dividend bit into the partial remainder.
    assign rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, dvs_q};
    assign rem_ge   = !rem_diff[XLEN];

    // On the fast path the fixup sees live operands while still in IDLE.
    logic            fx_live;
    div_op_e         fx_op;
    logic            fx_zero, fx_ovf;
    logic [XLEN-1:0] fx_dividend, fx_result;

    assign fx_live     = FAST_SPECIAL && (state_q == IDLE);
    assign fx_op       = fx_live ? div_op  : op_q;
    assign fx_zero     = fx_live ? in_zero : zero_q;
    assign fx_ovf      = fx_live ? in_ovf  : ovf_q;
    assign fx_dividend = fx_live ? src_a   : a_q;

    core_div_fixup #(.XLEN(XLEN)) u_fixup (
        .quo      (quo_q),
        .rem      (rem_q),
        .dividend (fx_dividend),
        .quo_neg  (quo_neg_q),
        .rem_neg  (rem_neg_q),
        .div_zero (fx_zero),
        .sgn_ovf  (fx_ovf),
        .op       (fx_op),
        .result   (fx_result)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (req_valid) state_d = (FAST_SPECIAL && special) ? DONE : CALC;
            CALC: if (cnt_q == 5'd0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= DIV_S;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            a_q       <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= div_op;
            quo_q     <= a_mag;
            rem_q     <= '0;
            dvs_q     <= b_mag;
            a_q       <= src_a;
            quo_neg_q <= in_sgn && (src_a[XLEN-1] ^ src_b[XLEN-1]);
            rem_neg_q <= in_sgn && src_a[XLEN-1];
            zero_q    <= in_zero;
            ovf_q     <= in_ovf;
            cnt_q     <= 5'(DIV_CYCLES - 1);
            if (FAST_SPECIAL && special) result_q <= fx_result;
        end else if (state_q == CALC) begin
            rem_q <= rem_ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], rem_ge};
            if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end else if (state_q == FIX) begin
            result_q <= fx_result;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_core_div.sv
// Directed self-checking bench for core_div: arithmetic, corner cases, latency, stall, flush, reset.
module tb_core_div;
    import core_pkg::*;

`ifdef CORE_DIV_FAST_SPECIAL_EN
    localparam int SPL_LAT = 1;
`else
    localparam int SPL_LAT = 34;
`endif
    localparam int LAT = 34;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, flush, resp_valid, resp_ready;
    div_op_e     div_op;
    logic [31:0] src_a, src_b, result;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    core_div #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .div_op     (div_op),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Request is accepted at the next edge; operands are then scrambled.
    task automatic do_req(input div_op_e op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        div_op    = op;
        src_a     = a;
        src_b     = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        src_a     = 32'hDEAD_BEEF;
        src_b     = 32'h0000_0003;
    endtask

    task automatic wait_resp(input string tag, input int exp_lat);
        int n = 1;
        while (!resp_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
    endtask

    task automatic handshake(input string tag);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk({tag, "_hs_vld"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_hs_rdy"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run(input string tag, input div_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        do_req(op, a, b);
        wait_resp(tag, lat);
        chk({tag, "_res"}, result, exp);
        handshake(tag);
    endtask

    initial begin
        int seen;
        rst = 1'b1; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        div_op = DIV_S; src_a = '0; src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run("divs_m7_2", DIV_S, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT);
        run("rems_m7_2", REM_S, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT);
        run("divs_7_m2", DIV_S, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT);
        run("rems_7_m2", REM_S, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT);
        run("divu_max_16", DIV_U, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT);
        run("remu_max_16", REM_U, 32'hFFFF_FFFF, 32'd16, 32'h0000_000F, LAT);
        run("divs_5_0", DIV_S, 32'd5, 32'd0, 32'hFFFF_FFFF, SPL_LAT);
        run("remu_5_0", REM_U, 32'd5, 32'd0, 32'd5, SPL_LAT);
        run("rems_m5_0", REM_S, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPL_LAT);
        run("divs_ovf", DIV_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPL_LAT);
        run("rems_ovf", REM_S, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPL_LAT);
        run("divu_nonovf", DIV_U, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT);
        run("remu_nonovf", REM_U, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT);

        // Flush while CALC has count==10 (21 iterations after acceptance).
        do_req(DIV_U, 32'h1234_5678, 32'd3);
        repeat (21) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
        chk("flush_resp_valid", {31'd0, resp_valid}, 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1;
        end
        chk("flush_no_resp", 32'(seen), 32'd0);
        run("divu_100_7", DIV_U, 32'd100, 32'd7, 32'd14, LAT);

        // Flush beats a simultaneous request in IDLE.
        req_valid = 1'b1; flush = 1'b1; div_op = DIV_U; src_a = 32'd9; src_b = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("flush_prio_rdy", {31'd0, req_ready}, 32'd1);

        // Consumer stalls for 5 cycles in DONE.
        do_req(DIV_U, 32'd1000, 32'd10);
        wait_resp("stall", LAT);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_vld", {31'd0, resp_valid}, 32'd1);
            chk("stall_res", result, 32'd100);
        end
        handshake("stall");

        // Synchronous reset in the middle of CALC.
        do_req(DIV_U, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        run("after_rst", DIV_U, 32'd1000, 32'd7, 32'd142, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
